// File: rtl/alu_pkg.sv
// Shared opcodes, flag indices and FSM state for the ALU command sequencer.
// Also holds the opcode-legality and settle-time helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_MULT   = 4'b0010;
  localparam logic [3:0] OP_DIV    = 4'b0011;
  localparam logic [3:0] OP_AND    = 4'b0100;
  localparam logic [3:0] OP_OR     = 4'b0101;
  localparam logic [3:0] OP_XOR    = 4'b0110;
  localparam logic [3:0] OP_NOT    = 4'b0111;
  localparam logic [3:0] OP_NAND   = 4'b1000;
  localparam logic [3:0] OP_NOR    = 4'b1001;
  localparam logic [3:0] OP_LSHIFT = 4'b1010;
  localparam logic [3:0] OP_RSHIFT = 4'b1011;
  localparam logic [3:0] OP_IDLE   = 4'b1100;

  localparam int FLG_COUT = 4;
  localparam int FLG_Z    = 3;
  localparam int FLG_N    = 2;
  localparam int FLG_C    = 1;
  localparam int FLG_V    = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Opcodes 1100-1111 are unused by the ALU.
  function automatic logic op_legal(input logic [3:0] op);
    return !(op[3] && op[2]);
  endfunction

  function automatic logic [7:0] settle_cycles(
    input logic [3:0] op,
    input int base_w,
    input int mul_w,
    input int div_w
  );
    if (op == OP_DIV)  return 8'(div_w);
    if (op == OP_MULT) return 8'(mul_w);
    return 8'(base_w);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle of the ALU command sequencer.
// master = command producer / response consumer, slave = sequencer.
interface alu_cmd_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      cmd_a;
  logic [15:0]      cmd_b;
  logic [3:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [15:0]      rsp_remainder;
  logic [4:0]       rsp_flags;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  cmd_ready,
    input  rsp_valid, rsp_result, rsp_remainder,
    input  rsp_flags, rsp_err, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output cmd_ready,
    output rsp_valid, rsp_result, rsp_remainder,
    output rsp_flags, rsp_err, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with async reset and occupancy count.
// Pushes into a full FIFO are dropped even if a pop happens that cycle.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_q];

  // Pointer, storage and occupancy update for this cycle.
  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues tagged ALU commands, drives the ALU, waits the settle time and
// returns the captured result on a backpressured response channel.
module alu_cmd_sequencer #(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4,
  parameter int BASE_WAIT = 1,
  parameter int MUL_WAIT  = 2,
  parameter int DIV_WAIT  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_cmd_sequencer_if.slave     bus,
  output logic [15:0]            alu_a,
  output logic [15:0]            alu_b,
  output logic [3:0]             alu_operation,
  input  logic [31:0]            alu_result,
  input  logic [15:0]            alu_remainder,
  input  logic                   alu_c_out,
  input  logic                   alu_z,
  input  logic                   alu_n,
  input  logic                   alu_c,
  input  logic                   alu_v,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] cmd_count
);
  import alu_pkg::*;

  localparam int EW = 36 + TAG_W;

  logic [EW-1:0]    fifo_din;
  logic [EW-1:0]    fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [15:0]      head_a;
  logic [15:0]      head_b;
  logic [3:0]       head_op;
  logic [TAG_W-1:0] head_tag;
  logic             head_legal;
  logic             issue;
  logic             finish;

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [15:0]      alu_a_q, alu_a_d;
  logic [15:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      res_q, res_d;
  logic [15:0]      rem_q, rem_d;
  logic [4:0]       flg_q, flg_d;
  logic             err_q, err_d;

  assign fifo_din = {bus.cmd_tag, bus.cmd_op, bus.cmd_b, bus.cmd_a};
  assign {head_tag, head_op, head_b, head_a} = fifo_dout;
  assign head_legal = op_legal(head_op);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid),
    .din   (fifo_din),
    .pop   (issue),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cmd_count)
  );

  assign issue = !fifo_empty &&
    ((state_q == ST_IDLE) ||
     ((state_q == ST_RESP) && bus.rsp_ready));
  assign finish = (state_q == ST_WAIT) && (wait_q == 8'd1);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: issue from IDLE/RESP, leave WAIT when settled.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (issue) state_d = head_legal ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (finish) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          if (issue) state_d = head_legal ? ST_WAIT : ST_RESP;
          else       state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: ALU drive on legal issue, response capture otherwise.
  always_comb begin
    wait_d   = wait_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    tag_d    = tag_q;
    res_d    = res_q;
    rem_d    = rem_q;
    flg_d    = flg_q;
    err_d    = err_q;
    if (state_q == ST_WAIT) wait_d = wait_q - 8'd1;
    unique case (1'b1)
      issue && head_legal: begin
        alu_a_d  = head_a;
        alu_b_d  = head_b;
        alu_op_d = head_op;
        tag_d    = head_tag;
        wait_d   = settle_cycles(head_op, BASE_WAIT,
                                 MUL_WAIT, DIV_WAIT);
      end
      issue && !head_legal: begin
        tag_d = head_tag;
        res_d = '0;
        rem_d = '0;
        flg_d = '0;
        err_d = 1'b1;
      end
      finish: begin
        res_d           = alu_result;
        rem_d           = alu_remainder;
        flg_d[FLG_COUT] = alu_c_out;
        flg_d[FLG_Z]    = alu_z;
        flg_d[FLG_N]    = alu_n;
        flg_d[FLG_C]    = alu_c;
        flg_d[FLG_V]    = alu_v;
        err_d = (alu_op_q == OP_DIV) && (alu_b_q == '0);
      end
      default: ;
    endcase
  end

  // Datapath registers; the ALU idles on an unused opcode after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q   <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_IDLE;
      tag_q    <= '0;
      res_q    <= '0;
      rem_q    <= '0;
      flg_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      tag_q    <= tag_d;
      res_q    <= res_d;
      rem_q    <= rem_d;
      flg_q    <= flg_d;
      err_q    <= err_d;
    end
  end

  assign alu_a             = alu_a_q;
  assign alu_b             = alu_b_q;
  assign alu_operation     = alu_op_q;
  assign busy              = (state_q != ST_IDLE);
  assign bus.cmd_ready     = !fifo_full;
  assign bus.rsp_valid     = (state_q == ST_RESP);
  assign bus.rsp_result    = res_q;
  assign bus.rsp_remainder = rem_q;
  assign bus.rsp_flags     = flg_q;
  assign bus.rsp_err       = err_q;
  assign bus.rsp_tag       = tag_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU
// and a queue-based response reference model.
module tb_alu_cmd_sequencer;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] res;
    logic [15:0] rem;
    logic [4:0]  flg;
  } alu_out_t;

  typedef struct packed {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [31:0]      res;
    logic [15:0]      rem;
    logic [4:0]       flg;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_operation;
  logic [31:0] alu_result;
  logic [15:0] alu_remainder;
  logic        alu_c_out, alu_z, alu_n, alu_c, alu_v;
  logic        busy;
  logic [2:0]  cmd_count;
  alu_out_t    ao;
  int          n_vec = 0;
  int          n_bad = 0;
  cmd_t        exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.TAG_W(TAG_W)) bus ();

  alu_cmd_sequencer #(
    .DEPTH(DEPTH), .TAG_W(TAG_W),
    .BASE_WAIT(1), .MUL_WAIT(2), .DIV_WAIT(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_remainder(alu_remainder),
    .alu_c_out(alu_c_out), .alu_z(alu_z), .alu_n(alu_n),
    .alu_c(alu_c), .alu_v(alu_v),
    .busy(busy), .cmd_count(cmd_count)
  );

  // Behavioural 16-bit ALU: result sign-extended, flags {cout,Z,N,C,V}.
  function automatic alu_out_t alu_fn(input logic [15:0] a,
                                      input logic [15:0] b,
                                      input logic [3:0] op);
    alu_out_t o;
    logic [16:0] s;
    logic signed [31:0] pa, pb;
    logic signed [15:0] sa, sb, q, r;
    o = '0;
    pa = {{16{a[15]}}, a};
    pb = {{16{b[15]}}, b};
    sa = a;
    sb = b;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        o.res = {{16{s[15]}}, s[15:0]};
        o.flg[4] = s[16];
        o.flg[1] = s[16];
        o.flg[0] = (a[15] == b[15]) && (s[15] != a[15]);
      end
      4'd1: begin
        s = {1'b0, a} - {1'b0, b};
        o.res = {{16{s[15]}}, s[15:0]};
        o.flg[4] = s[16];
        o.flg[1] = s[16];
        o.flg[0] = (a[15] != b[15]) && (s[15] != a[15]);
      end
      4'd2: o.res = pa * pb;
      4'd3: begin
        if (b != 16'h0) begin
          q = sa / sb;
          r = sa % sb;
          o.res = {{16{q[15]}}, q};
          o.rem = r;
        end
      end
      4'd4:  o.res = {16'h0, a & b};
      4'd5:  o.res = {16'h0, a | b};
      4'd6:  o.res = {16'h0, a ^ b};
      4'd7:  o.res = {16'h0, ~a};
      4'd8:  o.res = {16'h0, ~(a & b)};
      4'd9:  o.res = {16'h0, ~(a | b)};
      4'd10: o.res = {16'h0, a << b[3:0]};
      4'd11: o.res = {16'h0, a >> b[3:0]};
      default: o.res = '0;
    endcase
    if (op < 4'd12) begin
      o.flg[3] = (o.res == 32'h0);
      o.flg[2] = o.res[31];
    end
    return o;
  endfunction

  assign ao            = alu_fn(alu_a, alu_b, alu_operation);
  assign alu_result    = ao.res;
  assign alu_remainder = ao.rem;
  assign alu_c_out     = ao.flg[4];
  assign alu_z         = ao.flg[3];
  assign alu_n         = ao.flg[2];
  assign alu_c         = ao.flg[1];
  assign alu_v         = ao.flg[0];

  function automatic int settle_ref(input logic [3:0] op);
    if (op == 4'd3) return 4;
    if (op == 4'd2) return 2;
    return 1;
  endfunction

  function automatic int gap_ref(input logic [3:0] op);
    return (op >= 4'd12) ? 0 : settle_ref(op);
  endfunction

  function automatic rsp_t expect_rsp(input cmd_t c);
    rsp_t r;
    alu_out_t o;
    r = '0;
    r.tag = c.tag;
    if (c.op >= 4'd12) begin
      r.err = 1'b1;
    end else begin
      o = alu_fn(c.a, c.b, c.op);
      r.res = o.res;
      r.rem = o.rem;
      r.flg = o.flg;
      r.err = (c.op == 4'd3) && (c.b == 16'h0);
    end
    return r;
  endfunction

  function automatic rsp_t got_rsp();
    return {bus.rsp_result, bus.rsp_remainder, bus.rsp_flags,
            bus.rsp_err, bus.rsp_tag};
  endfunction

  function automatic cmd_t rand_cmd(input int t);
    cmd_t c;
    c.a = 16'($urandom);
    c.b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    if ($urandom_range(0, 7) == 0) c.op = 4'(12 + $urandom_range(0, 3));
    else c.op = 4'($urandom_range(0, 11));
    if (c.op == 4'd3 && c.a == 16'h8000 && c.b == 16'hFFFF) c.b = 16'h3;
    c.tag = TAG_W'(t);
    return c;
  endfunction

  function automatic cmd_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] op, input int t);
    cmd_t c;
    c.a = a; c.b = b; c.op = op; c.tag = TAG_W'(t);
    return c;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input cmd_t c);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = c.a;
    bus.cmd_b     = c.b;
    bus.cmd_op    = c.op;
    bus.cmd_tag   = c.tag;
  endtask

  // Offers one command, then counts edges from accept to rsp_valid.
  task automatic send_and_wait(input cmd_t c, output int lat);
    int k;
    k = 0;
    drive_cmd(c);
    while (!bus.cmd_ready && k < 50) begin tick; k++; end
    tick;
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin tick; lat++; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0; bus.cmd_tag = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick;
    n_vec++;
    if (alu_operation !== 4'b1100) begin
      n_bad++;
      $display("FAIL reset_alu_op got=%b want=1100", alu_operation);
    end
    rst = 1'b0;
    tick;
    n_vec++;
    if (bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid);
    end
    n_vec++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready);
    end
    n_vec++;
    if ({busy, cmd_count, alu_a, alu_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b/%0d/%h/%h want=0",
               busy, cmd_count, alu_a, alu_b);
    end
    n_vec++;
    if (got_rsp() !== '0) begin
      n_bad++;
      $display("FAIL reset_rsp got=%h want=0", got_rsp());
    end
  endtask

  task automatic test_add;
    int lat;
    rsp_t r;
    cmd_t c;
    c = mk(16'h7FFF, 16'h0001, 4'd0, 3);
    send_and_wait(c, lat);
    r = got_rsp();
    n_vec++;
    if (lat != 2) begin
      n_bad++;
      $display("FAIL add_latency got=%0d want=2", lat);
    end
    n_vec++;
    if (r.res !== 32'hFFFF8000 || r.flg !== 5'b00101 ||
        r.tag !== 4'd3 || r.err !== 1'b0) begin
      n_bad++;
      $display("FAIL add_rsp got=%h/%b/%h/%b want=ffff8000/00101/3/0",
               r.res, r.flg, r.tag, r.err);
    end
    tick;
  endtask

  task automatic test_div;
    int lat;
    rsp_t r;
    send_and_wait(mk(16'hFFF9, 16'h0002, 4'd3, 5), lat);
    r = got_rsp();
    n_vec++;
    if (lat != 5) begin
      n_bad++;
      $display("FAIL div_latency got=%0d want=5", lat);
    end
    n_vec++;
    if (r.res !== 32'hFFFFFFFD || r.rem !== 16'hFFFF || r.err !== 1'b0) begin
      n_bad++;
      $display("FAIL div_rsp got=%h/%h/%b want=fffffffd/ffff/0",
               r.res, r.rem, r.err);
    end
    tick;
    send_and_wait(mk(16'h0005, 16'h0000, 4'd3, 6), lat);
    r = got_rsp();
    n_vec++;
    if (lat != 5 || r.res !== 32'h0 || r.err !== 1'b1 || r.tag !== 4'd6) begin
      n_bad++;
      $display("FAIL div0_rsp got=lat%0d/%h/%b/%h want=lat5/0/1/6",
               lat, r.res, r.err, r.tag);
    end
    tick;
  endtask

  task automatic test_illegal;
    int lat;
    rsp_t r;
    send_and_wait(mk(16'h1234, 16'h5678, 4'b1101, 9), lat);
    r = got_rsp();
    n_vec++;
    if (lat != 1) begin
      n_bad++;
      $display("FAIL illegal_latency got=%0d want=1", lat);
    end
    n_vec++;
    if (r !== {32'h0, 16'h0, 5'h0, 1'b1, 4'd9}) begin
      n_bad++;
      $display("FAIL illegal_rsp got=%h want=err,tag9", r);
    end
    n_vec++;
    if (alu_operation !== 4'b0011 || alu_b !== 16'h0) begin
      n_bad++;
      $display("FAIL illegal_alu_drive got=%b/%h want=0011/0000",
               alu_operation, alu_b);
    end
    tick;
  endtask

  task automatic test_mult_and;
    int lat;
    int n;
    rsp_t r;
    drive_cmd(mk(16'hFED4, 16'h00C8, 4'd2, 1));
    tick;
    drive_cmd(mk(16'h00F0, 16'h0FF0, 4'd4, 2));
    tick;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin tick; lat++; end
    r = got_rsp();
    n_vec++;
    if (lat != 3 || r.res !== 32'hFFFF15A0 || r.tag !== 4'd1) begin
      n_bad++;
      $display("FAIL mult_rsp got=lat%0d/%h/%h want=lat3/ffff15a0/1",
               lat, r.res, r.tag);
    end
    tick;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin tick; n++; end
    r = got_rsp();
    n_vec++;
    if (n != 1 || r.res !== 32'h000000F0 || r.tag !== 4'd2) begin
      n_bad++;
      $display("FAIL and_rsp got=gap%0d/%h/%h want=gap1/000000f0/2",
               n, r.res, r.tag);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    cmd_t cs[6];
    rsp_t r0;
    int acc;
    int k;
    for (int i = 0; i < 6; i++) cs[i] = rand_cmd(i);
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 40 && acc < 5; j++) begin
      drive_cmd(cs[acc]);
      if (bus.cmd_ready) acc++;
      tick;
    end
    drive_cmd(cs[5]);
    n_vec++;
    if (acc != 5 || bus.cmd_ready !== 1'b0 || cmd_count !== 3'd4) begin
      n_bad++;
      $display("FAIL b2b_full got=acc%0d/rdy%b/cnt%0d want=acc5/rdy0/cnt4",
               acc, bus.cmd_ready, cmd_count);
    end
    k = 0;
    while (!bus.rsp_valid && k < 20) begin tick; k++; end
    r0 = got_rsp();
    n_vec++;
    if (r0 !== expect_rsp(cs[0])) begin
      n_bad++;
      $display("FAIL b2b_first got=%h want=%h", r0, expect_rsp(cs[0]));
    end
    repeat (3) tick;
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || got_rsp() !== r0 ||
        bus.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_hold got=v%b/%h/rdy%b want=v1/%h/rdy0",
               bus.rsp_valid, got_rsp(), bus.cmd_ready, r0);
    end
    fork
      begin
        int m;
        m = 0;
        while (!bus.cmd_ready && m < 60) begin tick; m++; end
        tick;
        bus.cmd_valid = 1'b0;
      end
      begin
        int n;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          n = 0;
          while (!bus.rsp_valid && n < 40) begin tick; n++; end
          n_vec++;
          if (n != ((i == 0) ? 0 : gap_ref(cs[i].op)) ||
              got_rsp() !== expect_rsp(cs[i])) begin
            n_bad++;
            $display("FAIL b2b_rsp%0d got=gap%0d/%h want=gap%0d/%h", i, n,
                     got_rsp(), (i == 0) ? 0 : gap_ref(cs[i].op),
                     expect_rsp(cs[i]));
          end
          tick;
        end
      end
    join
    n_vec++;
    if (busy !== 1'b0 || cmd_count !== 3'd0) begin
      n_bad++;
      $display("FAIL b2b_drain got=busy%b/cnt%0d want=busy0/cnt0",
               busy, cmd_count);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    int seen;
    bus.rsp_ready = 1'b1;
    drive_cmd(mk(16'd100, 16'd7, 4'd3, 1));
    tick;
    drive_cmd(mk(16'd1, 16'd2, 4'd0, 2));
    tick;
    drive_cmd(mk(16'd3, 16'd4, 4'd0, 3));
    tick;
    bus.cmd_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || cmd_count !== 3'd2 || bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_pre got=busy%b/cnt%0d want=busy1/cnt2",
               busy, cmd_count);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || cmd_count !== 3'd0 ||
        alu_operation !== 4'b1100 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_wait got=v%b/cnt%0d/op%b/busy%b want=0/0/1100/0",
               bus.rsp_valid, cmd_count, alu_operation, busy);
    end
    tick;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus.rsp_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL rstmid_stale got=%0d want=0", seen);
    end
    bus.rsp_ready = 1'b0;
    send_and_wait(mk(16'd9, 16'd9, 4'd6, 4), k);
    n_vec++;
    if (bus.rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstresp_pre got=%b want=1", bus.rsp_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || got_rsp() !== '0) begin
      n_bad++;
      $display("FAIL rstresp_drop got=v%b/%h want=0/0",
               bus.rsp_valid, got_rsp());
    end
    tick;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    tick;
  endtask

  task automatic test_random;
    localparam int N = 40;
    exp_q.delete();
    fork
      begin
        cmd_t c;
        int k;
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.cmd_valid = 1'b0;
            tick;
          end
          c = rand_cmd(i);
          drive_cmd(c);
          k = 0;
          while (!bus.cmd_ready && k < 200) begin tick; k++; end
          exp_q.push_back(c);
          tick;
        end
        bus.cmd_valid = 1'b0;
      end
      begin
        int got;
        int cyc;
        logic held;
        rsp_t hv;
        rsp_t e;
        got = 0;
        cyc = 0;
        held = 1'b0;
        hv = '0;
        while (got < N && cyc < 3000) begin
          if (held) begin
            n_vec++;
            if (bus.rsp_valid !== 1'b1 || got_rsp() !== hv) begin
              n_bad++;
              $display("FAIL rand_hold got=v%b/%h want=v1/%h",
                       bus.rsp_valid, got_rsp(), hv);
            end
          end
          bus.rsp_ready = 1'($urandom_range(0, 1));
          held = bus.rsp_valid && !bus.rsp_ready;
          hv = got_rsp();
          if (bus.rsp_valid && bus.rsp_ready) begin
            e = (exp_q.size() > 0) ? expect_rsp(exp_q.pop_front()) : '1;
            n_vec++;
            if (got_rsp() !== e) begin
              n_bad++;
              $display("FAIL rand_rsp%0d got=%h want=%h", got, got_rsp(), e);
            end
            got++;
          end
          tick;
          cyc++;
        end
        n_vec++;
        if (got != N) begin
          n_bad++;
          $display("FAIL rand_count got=%0d want=%0d", got, N);
        end
      end
    join
    bus.rsp_ready = 1'b1;
  endtask

  initial begin
    test_reset;
    test_add;
    test_div;
    test_illegal;
    test_mult_and;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
